// File: rtl/wb_ram_arb.sv
// wb_ram_arb: two-master Wishbone arbiter in front of a single wb_ram port.
// A grant is taken per CYC and held until the granted master drops CYC.
// ACK is returned only to the granted master. A stall watchdog ends a hung
// strobe with a one-cycle ERR pulse.
module wb_ram_arb #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int SELECT_WIDTH    = DATA_WIDTH/8,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int TIMEOUT         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  // master 1
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  // RAM port
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  // status
  output logic [1:0]              grant_o
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;     // 0 = master 0 last granted, 1 = master 1
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rearb;
  logic          stb_sel;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT > 0) && (tcnt_q == TW'(TIMEOUT));

  // State registers; last resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Arbitration: only when idle or the owner has released CYC.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    rearb   = (grant_q == 2'b00) || (grant_q[0] && !m0_cyc_i) || (grant_q[1] && !m1_cyc_i);
    if (rearb) begin
      unique case ({m1_cyc_i, m0_cyc_i})
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = ((ARB_ROUND_ROBIN != 0) && !last_q) ? 2'b10 : 2'b01;
        default: grant_d = 2'b00;
      endcase
      if (grant_d != 2'b00) begin
        last_d = grant_d[1];
      end
    end
  end

  // Request mux toward the RAM; idle grant passes master 0 buses with CYC/STB low.
  always_comb begin
    wb_adr_o = m0_adr_i;
    wb_dat_o = m0_dat_i;
    wb_we_o  = m0_we_i;
    wb_sel_o = m0_sel_i;
    wb_cyc_o = 1'b0;
    stb_sel  = 1'b0;
    if (grant_q[1]) begin
      wb_adr_o = m1_adr_i;
      wb_dat_o = m1_dat_i;
      wb_we_o  = m1_we_i;
      wb_sel_o = m1_sel_i;
      wb_cyc_o = m1_cyc_i;
      stb_sel  = m1_stb_i;
    end else if (grant_q[0]) begin
      wb_cyc_o = m0_cyc_i;
      stb_sel  = m0_stb_i;
    end
    wb_stb_o = stb_sel & ~timeout_hit;
  end

  // Watchdog: counts stalled strobe cycles, restarts on ACK, idle or expiry.
  always_comb begin
    if ((TIMEOUT == 0) || (grant_q == 2'b00) || !stb_sel || wb_ack_i || timeout_hit) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Response routing; ACK is masked during an ERR cycle so the two never coincide.
  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;
  assign m0_ack_o = wb_ack_i & grant_q[0] & ~timeout_hit;
  assign m1_ack_o = wb_ack_i & grant_q[1] & ~timeout_hit;
  assign m0_err_o = timeout_hit & grant_q[0];
  assign m1_err_o = timeout_hit & grant_q[1];
  assign grant_o  = grant_q;

endmodule

// File: tb/tb_wb_ram_arb.sv
// Bench for wb_ram_arb: a round-robin instance (TIMEOUT=4) and a fixed-priority
// instance (watchdog disabled) share the master stimulus, each with its own RAM slave.
module tb_wb_ram_arb;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat;
  logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          force_noack;

  logic [DW-1:0] rr_m0_dat, rr_m1_dat, rr_wb_dat, rr_ram_dat;
  logic          rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
  logic [AW-1:0] rr_wb_adr;
  logic          rr_wb_we, rr_wb_stb, rr_wb_cyc, rr_ram_ack;
  logic [SW-1:0] rr_wb_sel;
  logic [1:0]    rr_grant;

  logic [DW-1:0] fp_m0_dat, fp_m1_dat, fp_wb_dat, fp_ram_dat;
  logic          fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
  logic [AW-1:0] fp_wb_adr;
  logic          fp_wb_we, fp_wb_stb, fp_wb_cyc, fp_ram_ack;
  logic [SW-1:0] fp_wb_sel;
  logic [1:0]    fp_grant;

  int tests = 0;
  int fails = 0;

  wb_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_ROUND_ROBIN(1), .TIMEOUT(4)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(rr_m0_dat), .m0_ack_o(rr_m0_ack), .m0_err_o(rr_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(rr_m1_dat), .m1_ack_o(rr_m1_ack), .m1_err_o(rr_m1_err),
    .wb_adr_o(rr_wb_adr), .wb_dat_o(rr_wb_dat), .wb_we_o(rr_wb_we), .wb_sel_o(rr_wb_sel),
    .wb_stb_o(rr_wb_stb), .wb_cyc_o(rr_wb_cyc), .wb_dat_i(rr_ram_dat), .wb_ack_i(rr_ram_ack),
    .grant_o(rr_grant));

  wb_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(fp_m0_dat), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(fp_m1_dat), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
    .wb_adr_o(fp_wb_adr), .wb_dat_o(fp_wb_dat), .wb_we_o(fp_wb_we), .wb_sel_o(fp_wb_sel),
    .wb_stb_o(fp_wb_stb), .wb_cyc_o(fp_wb_cyc), .wb_dat_i(fp_ram_dat), .wb_ack_i(fp_ram_ack),
    .grant_o(fp_grant));

  // RAM slave for the round-robin instance: registered ACK one cycle after STB.
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ram_ack <= 1'b0;
      rr_ram_dat <= '0;
    end else begin
      rr_ram_ack <= rr_wb_stb & rr_wb_cyc & ~rr_ram_ack & ~force_noack;
      if (rr_wb_stb && rr_wb_cyc && !rr_ram_ack) rr_ram_dat <= mem[rr_wb_adr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (!rst && rr_wb_stb && rr_wb_cyc && !rr_ram_ack && rr_wb_we)
      for (int b = 0; b < SW; b++)
        if (rr_wb_sel[b]) mem[rr_wb_adr[7:0]][8*b +: 8] <= rr_wb_dat[8*b +: 8];
  end

  // Slave for the fixed-priority instance: ACK only, data is a tag of the address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_ram_ack <= 1'b0;
      fp_ram_dat <= '0;
    end else begin
      fp_ram_ack <= fp_wb_stb & fp_wb_cyc & ~fp_ram_ack;
      fp_ram_dat <= {16'hA5A5, fp_wb_adr};
    end
  end

  // Expected master/RAM-side view given the model's owner (-1 idle, 0, 1).
  function automatic logic [124:0] exp_vec(input int o, input logic ack, input logic [DW-1:0] rdat);
    logic s1;
    s1 = (o == 1);
    return {(o == 0) ? 2'b01 : ((o == 1) ? 2'b10 : 2'b00),
            (o == 0) ? m0_cyc : ((o == 1) ? m1_cyc : 1'b0),
            (o == 0) ? m0_stb : ((o == 1) ? m1_stb : 1'b0),
            ack && (o == 0), ack && (o == 1), 1'b0, 1'b0,
            s1 ? m1_we : m0_we, s1 ? m1_sel : m0_sel, s1 ? m1_adr : m0_adr,
            s1 ? m1_dat : m0_dat, rdat, rdat};
  endfunction

  // Arbitration rules: owner keeps grant while CYC high, otherwise pick again.
  task automatic model_step(inout int o, inout int lst, input logic c0, input logic c1, input bit rrm);
    if (!((o == 0 && c0) || (o == 1 && c1))) begin
      if (c0 && c1)  o = (rrm && lst == 0) ? 1 : 0;
      else if (c0)   o = 0;
      else if (c1)   o = 1;
      else           o = -1;
      if (o >= 0) lst = o;
    end
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_all(); force_noack = 0;
    m0_adr = '0; m0_dat = '0; m0_we = 0; m0_sel = '1;
    m1_adr = '0; m1_dat = '0; m1_we = 0; m1_sel = '1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // One transfer on the round-robin instance; lat = -1 if no ACK within budget.
  task automatic xfer(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                      output logic [DW-1:0] rd, output int lat);
    if (m == 0) begin m0_adr = a; m0_dat = d; m0_we = we; m0_sel = '1; m0_cyc = 1; m0_stb = 1; end
    else        begin m1_adr = a; m1_dat = d; m1_we = we; m1_sel = '1; m1_cyc = 1; m1_stb = 1; end
    lat = -1; rd = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ((m == 0 && rr_m0_ack) || (m == 1 && rr_m1_ack)) begin
        lat = k; rd = (m == 0) ? rr_m0_dat : rr_m1_dat;
        break;
      end
    end
    if (m == 0) m0_stb = 0; else m1_stb = 0;
  endtask

  task automatic test_reset();
    rst = 1; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; force_noack = 0;
    m0_adr = '0; m0_dat = '0; m0_we = 0; m0_sel = '1;
    m1_adr = '0; m1_dat = '0; m1_we = 0; m1_sel = '1;
    #1;
    tests++;
    if ({rr_grant, fp_grant} !== 4'b0) begin fails++; $display("FAIL reset_grant: got %b/%b want 00/00", rr_grant, fp_grant); end
    @(negedge clk);
    tests++;
    if ({rr_wb_cyc, rr_wb_stb, fp_wb_cyc, fp_wb_stb} !== 4'b0) begin
      fails++; $display("FAIL reset_cycstb: got %b want 0000", {rr_wb_cyc, rr_wb_stb, fp_wb_cyc, fp_wb_stb}); end
    tests++;
    if ({rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err} !== 4'b0) begin
      fails++; $display("FAIL reset_ackerr: got %b want 0000", {rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err}); end
    idle_all(); rst = 0;
    @(negedge clk);
    tests++;
    if (rr_grant !== 2'b00) begin fails++; $display("FAIL reset_idle: got %b want 00", rr_grant); end
  endtask

  task automatic test_single();
    logic [DW-1:0] rd; int lat; logic m1_seen;
    do_reset();
    m0_adr = 16'h0010; m0_dat = 32'h11223344; m0_we = 1; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    m1_seen = rr_m1_ack;
    tests++;
    if ({rr_grant, rr_wb_stb, rr_m0_ack, rr_wb_adr, rr_wb_we} !== {2'b01, 1'b1, 1'b0, 16'h0010, 1'b1}) begin
      fails++; $display("FAIL single_grant_n1: got g=%b stb=%b ack=%b adr=%h we=%b want g=01 stb=1 ack=0 adr=0010 we=1",
                        rr_grant, rr_wb_stb, rr_m0_ack, rr_wb_adr, rr_wb_we); end
    @(negedge clk);
    m1_seen |= rr_m1_ack;
    tests++;
    if (rr_m0_ack !== 1'b1) begin fails++; $display("FAIL single_ack_n2: got %b want 1", rr_m0_ack); end
    xfer(0, 16'h0010, 32'h0, 1'b0, rd, lat);
    m1_seen |= rr_m1_ack;
    tests++;
    if (lat !== 1 || rd !== 32'h11223344) begin
      fails++; $display("FAIL single_read: got lat=%0d dat=%h want lat=1 dat=11223344", lat, rd); end
    tests++;
    if (m1_seen !== 1'b0) begin fails++; $display("FAIL single_m1_noack: got %b want 0", m1_seen); end
    idle_all(); @(negedge clk);
  endtask

  task automatic test_tie_rr();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b01) begin fails++; $display("FAIL tie_first: got %b want 01", rr_grant); end
    m0_cyc = 0;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b10) begin fails++; $display("FAIL tie_handover: got %b want 10", rr_grant); end
    m1_cyc = 0;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b00) begin fails++; $display("FAIL tie_idle: got %b want 00", rr_grant); end
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b01) begin fails++; $display("FAIL tie_second: got %b want 01", rr_grant); end
    idle_all(); @(negedge clk);
  endtask

  task automatic test_fixed();
    idle_all(); @(negedge clk);
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); tests++;
    if (fp_grant !== 2'b01) begin fails++; $display("FAIL fixed_tie1: got %b want 01", fp_grant); end
    idle_all(); @(negedge clk);
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); tests++;
    if (fp_grant !== 2'b01) begin fails++; $display("FAIL fixed_tie2: got %b want 01", fp_grant); end
    m0_cyc = 0;
    @(negedge clk); tests++;
    if (fp_grant !== 2'b10) begin fails++; $display("FAIL fixed_m1_after_idle: got %b want 10", fp_grant); end
    m0_cyc = 1;
    @(negedge clk); tests++;
    if (fp_grant !== 2'b10) begin fails++; $display("FAIL fixed_hold_m1: got %b want 10", fp_grant); end
    m1_cyc = 0;
    @(negedge clk); tests++;
    if (fp_grant !== 2'b01) begin fails++; $display("FAIL fixed_back_m0: got %b want 01", fp_grant); end
    idle_all(); @(negedge clk);
  endtask

  task automatic test_hold();
    logic [DW-1:0] wd [4]; logic [DW-1:0] rd; int lat;
    do_reset();
    m1_cyc = 1;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b10) begin fails++; $display("FAIL hold_grant_m1: got %b want 10", rr_grant); end
    m0_cyc = 1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      xfer(1, 16'h0020 + 16'(i), wd[i], 1'b1, rd, lat);
      tests++;
      if (lat < 0 || rr_grant !== 2'b10) begin
        fails++; $display("FAIL hold_write%0d: got lat=%0d g=%b want lat>=0 g=10", i, lat, rr_grant); end
    end
    m1_cyc = 0;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b01) begin fails++; $display("FAIL hold_release: got %b want 01", rr_grant); end
    for (int i = 0; i < 4; i++) begin
      xfer(0, 16'h0020 + 16'(i), 32'h0, 1'b0, rd, lat);
      tests++;
      if (lat < 0 || rd !== wd[i]) begin
        fails++; $display("FAIL hold_readback%0d: got lat=%0d dat=%h want dat=%h", i, lat, rd, wd[i]); end
    end
    idle_all(); @(negedge clk);
  endtask

  task automatic test_watchdog();
    logic e0, s;
    do_reset();
    force_noack = 1;
    m0_adr = 16'h0055; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      e0 = (c == 5);
      s  = (c != 5);
      tests++;
      if ({rr_m0_err, rr_m1_err, rr_wb_stb, rr_m0_ack, rr_grant} !== {e0, 1'b0, s, 1'b0, 2'b01}) begin
        fails++; $display("FAIL watchdog_c%0d: got err0=%b err1=%b stb=%b ack=%b g=%b want err0=%b err1=0 stb=%b ack=0 g=01",
                          c, rr_m0_err, rr_m1_err, rr_wb_stb, rr_m0_ack, rr_grant, e0, s); end
    end
    idle_all(); force_noack = 0; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; int lat;
    do_reset();
    xfer(1, 16'h0040, 32'hCAFE0001, 1'b1, rd, lat);
    m1_stb = 1; m1_adr = 16'h0041;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b10 || rr_wb_stb !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got g=%b stb=%b want g=10 stb=1", rr_grant, rr_wb_stb); end
    #2 rst = 1;
    #1; tests++;
    if ({rr_wb_cyc, rr_wb_stb, rr_grant, rr_m0_ack, rr_m1_ack} !== 6'b0) begin
      fails++; $display("FAIL rstmid_immediate: got cyc=%b stb=%b g=%b ack=%b%b want all 0",
                        rr_wb_cyc, rr_wb_stb, rr_grant, rr_m0_ack, rr_m1_ack); end
    m0_cyc = 1; m1_stb = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk); tests++;
    if (rr_grant !== 2'b01) begin fails++; $display("FAIL rstmid_tie_after: got %b want 01", rr_grant); end
    idle_all(); @(negedge clk);
  endtask

  task automatic test_random();
    int ro, rl, fo, fl;
    int bad_rr, bad_fp;
    do_reset();
    ro = -1; rl = 1; fo = -1; fl = 1;
    bad_rr = 0; bad_fp = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc & 1'($urandom_range(0, 1));
      m1_stb = m1_cyc & 1'($urandom_range(0, 1));
      m0_adr = 16'($urandom); m1_adr = 16'($urandom);
      m0_dat = $urandom; m1_dat = $urandom;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      #1;
      tests++;
      if ({rr_grant, rr_wb_cyc, rr_wb_stb, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err, rr_wb_we, rr_wb_sel,
           rr_wb_adr, rr_wb_dat, rr_m0_dat, rr_m1_dat} !== exp_vec(ro, rr_ram_ack, rr_ram_dat)) begin
        fails++; bad_rr++;
        if (bad_rr < 5) $display("FAIL random_rr cycle %0d: got %h want %h", n,
          {rr_grant, rr_wb_cyc, rr_wb_stb, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err, rr_wb_we, rr_wb_sel,
           rr_wb_adr, rr_wb_dat, rr_m0_dat, rr_m1_dat}, exp_vec(ro, rr_ram_ack, rr_ram_dat));
      end
      tests++;
      if ({fp_grant, fp_wb_cyc, fp_wb_stb, fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err, fp_wb_we, fp_wb_sel,
           fp_wb_adr, fp_wb_dat, fp_m0_dat, fp_m1_dat} !== exp_vec(fo, fp_ram_ack, fp_ram_dat)) begin
        fails++; bad_fp++;
        if (bad_fp < 5) $display("FAIL random_fp cycle %0d: got %h want %h", n,
          {fp_grant, fp_wb_cyc, fp_wb_stb, fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err, fp_wb_we, fp_wb_sel,
           fp_wb_adr, fp_wb_dat, fp_m0_dat, fp_m1_dat}, exp_vec(fo, fp_ram_ack, fp_ram_dat));
      end
      model_step(ro, rl, m0_cyc, m1_cyc, 1'b1);
      model_step(fo, fl, m0_cyc, m1_cyc, 1'b0);
      @(negedge clk);
    end
    idle_all(); @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_tie_rr();
    test_fixed();
    test_hold();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_ram_arb.md
# wb_ram_arb

Two-master Wishbone arbiter that shares one `wb_ram` slave port between two requesters (e.g. a CPU data port and a DMA engine). It registers a grant per bus cycle (CYC), muxes the winning master onto the RAM port, routes ACK back only to the granted master, and runs a stall watchdog that terminates hung strobes with ERR. It sits directly in front of `wb_ram` at the same DATA/ADDR/SELECT widths.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 16, address width, passed through unchanged
- `SELECT_WIDTH`, `DATA_WIDTH/8`, byte-select width
- `ARB_ROUND_ROBIN`, 1, 1 = round-robin, 0 = fixed priority (master 0 wins)
- `TIMEOUT`, 16, stall cycles before ERR; 0 disables the watchdog

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `m0_adr_i / m0_dat_i / m0_we_i / m0_sel_i / m0_stb_i / m0_cyc_i`  in  ADDR/DATA/1/SELECT/1/1  master 0 request
- `m0_dat_o / m0_ack_o / m0_err_o`  out  DATA/1/1  master 0 response
- `m1_*`  same set as `m0_*`, master 1
- `wb_adr_o / wb_dat_o / wb_we_o / wb_sel_o / wb_stb_o / wb_cyc_o`  out  ADDR/DATA/1/SELECT/1/1  to RAM
- `wb_dat_i / wb_ack_i`  in  DATA/1  from RAM
- `grant_o`  out  2  one-hot current grant (status)

## Operation
- Registered state: `grant` (one-hot, 2 bits, 00 = idle), `last` (last granted master), `tcnt` (watchdog counter, `$clog2(TIMEOUT+1)` bits).
- Arbitration each cycle where current grant is idle or granted master's `cyc_i` is low: requests = `{m1_cyc_i, m0_cyc_i}`.
  - none -> grant 00.
  - one -> grant that master.
  - both, round-robin -> master != `last`; fixed -> master 0.
  - `last` updates whenever a new non-idle grant is loaded.
- Grant held for the whole CYC of the granted master, regardless of the other master's requests. Re-arbitration on release happens in the same cycle (no dead cycle if the other master waits).
- Mux (combinational from `grant`): adr/dat/we/sel from granted master; `wb_cyc_o = granted cyc_i`, `wb_stb_o = granted stb_i & ~timeout_hit`; with grant 00 both are 0, other buses pass master 0 values.
- Return: `mX_dat_o = wb_dat_i` for both; `mX_ack_o = wb_ack_i & grant[X]`; ACK arriving for an ungranted master is dropped.
- Watchdog (TIMEOUT>0): `tcnt` clears when no grant, `wb_stb_o` low, or `wb_ack_i` high; else increments. `timeout_hit = (tcnt == TIMEOUT)`: `mX_err_o` pulses one cycle for the granted master, `wb_stb_o` forced low that cycle, `tcnt` clears. Grant is kept (master decides whether to drop CYC).
- Reset (async, any time, incl. mid-transfer): grant 00, `last` = master 1 (so master 0 wins first tie), `tcnt` 0. Immediately: `wb_cyc_o`/`wb_stb_o`/all ACK/ERR = 0, `grant_o` = 00.

## Timing
- Request raised in cycle N from idle -> `grant_o` valid and `wb_stb_o` high in N+1 -> `wb_ram` ACK (and `mX_ack_o`) in N+2. Back-to-back strobes under a held grant follow `wb_ram` timing unchanged.
- Handover: granted master drops CYC in cycle N -> waiting master granted and strobing in N+1.
- Watchdog: stb high with no ACK from cycle S -> ERR in cycle S+TIMEOUT.
- ERR and ACK never assert together; ACK/ERR never reach the ungranted master.

## Test plan
- Single master: m0 write 0x11223344 @0x0010 sel=F, then read -> grant 01 in N+1, ack N+2, read data 0x11223344; m1 sees no ACK.
- Tie, round-robin: both raise CYC same cycle after reset -> m0 first; m0 drops CYC -> m1 granted next cycle; next tie -> m0.
- Fixed priority (`ARB_ROUND_ROBIN=0`): repeated ties -> m0 always wins; m1 waits until m0 idle.
- Hold: m1 holds CYC for 4 writes while m0 requests -> m0 starves until m1 drops CYC, then granted next cycle; RAM contents match m1 writes.
- Watchdog (TIMEOUT=4, `wb_ack_i` forced 0): m0 strobes -> `m0_err_o` single pulse 4 cycles after first stb, `wb_stb_o` low that cycle, no ACK.
- Reset mid-burst: assert `rst` while m1 strobing -> `wb_cyc_o`, `wb_stb_o`, `grant_o` 0 same cycle; after release tie goes to m0.
